// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer arbiter bus: scan-out fetch, pixel writer,
// clear control and single-port RAM signals.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [7:0]        disp_data;
    logic              disp_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              clr_start;
    logic [7:0]        clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
        output clr_start, clr_color, mem_rdata,
        input  disp_data, disp_valid, wr_ready, clr_busy, clr_done,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
        input  clr_start, clr_color, mem_rdata,
        output disp_data, disp_valid, wr_ready, clr_busy, clr_done,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display > clear > writer, one access
// per cycle, with a full-screen clear engine.
module vga_fb_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int FB_DEPTH = 19200
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_fb_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] clr_addr;
    logic [7:0]        clr_col;
    logic              rd_p1;
    logic              rd_p2;
    logic              wr_go;
    logic              clr_go;

    assign bus.wr_ready = rst_n && (state == IDLE) && !bus.disp_req;
    assign wr_go        = bus.wr_valid && bus.wr_ready;
    assign clr_go       = (state == CLEAR) && !bus.disp_req;
    assign bus.clr_busy = (state != IDLE);
    assign bus.clr_done = (state == DONE);

    // Clear sequencer: walks clr_addr across the frame, stalling on display.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_addr <= '0;
            clr_col  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_start) begin
                        state    <= CLEAR;
                        clr_col  <= bus.clr_color;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_go) begin
                        if (clr_addr == LAST) begin
                            state <= DONE;
                        end else begin
                            clr_addr <= clr_addr + ONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Registered RAM port: grant the highest-priority requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            unique case (1'b1)
                bus.disp_req: begin
                    bus.mem_en   <= 1'b1;
                    bus.mem_addr <= bus.disp_addr;
                end
                clr_go: begin
                    bus.mem_en    <= 1'b1;
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= clr_addr;
                    bus.mem_wdata <= clr_col;
                end
                wr_go: begin
                    bus.mem_en    <= 1'b1;
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= bus.wr_addr;
                    bus.mem_wdata <= bus.wr_data;
                end
                default: ;
            endcase
        end
    end

    // Read-return pipeline: fixed three-cycle display latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_p1          <= 1'b0;
            rd_p2          <= 1'b0;
            bus.disp_valid <= 1'b0;
            bus.disp_data  <= '0;
        end else begin
            rd_p1          <= bus.disp_req;
            rd_p2          <= rd_p1;
            bus.disp_valid <= rd_p2;
            if (rd_p2) begin
                bus.disp_data <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural
// single-port RAM behind the arbiter.
module tb_vga_fb_arbiter;
    localparam int AW    = 15;
    localparam int DEPTH = 19200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    logic [7:0] ram [DEPTH];
    logic [7:0] rdata;

    vga_fb_arbiter_if #(.ADDR_W(AW)) bus ();

    vga_fb_arbiter #(.ADDR_W(AW), .FB_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = rdata;

    // RAM model: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (bus.mem_en && int'(bus.mem_addr) < DEPTH) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            rdata <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        logic          dr;
        logic [AW-1:0] da;
        logic          wv;
        logic [AW-1:0] wa;
        logic [7:0]    wd;
        logic          rdy;
        logic          men;
        logic          mwe;
        logic [AW-1:0] ma;
        logic [7:0]    mwd;
        logic          dv;
        logic [7:0]    dd;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(
        input logic dr, input int da, input logic wv, input int wa,
        input logic [7:0] wd, input logic rdy, input logic men,
        input logic mwe, input int ma, input logic [7:0] mwd,
        input logic dv, input logic [7:0] dd);
        vec_t v;
        v.dr = dr; v.da = AW'(da); v.wv = wv; v.wa = AW'(wa);
        v.wd = wd; v.rdy = rdy; v.men = men; v.mwe = mwe;
        v.ma = AW'(ma); v.mwd = mwd; v.dv = dv; v.dd = dd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clr_start = 1'b0;
        bus.clr_color = '0;
    endtask

    task automatic ram_check(input string name, input int lo,
                             input int hi, input logic [7:0] col,
                             input logic use_pat);
        int bad = 0;
        for (int i = lo; i <= hi; i++) begin
            logic [7:0] e;
            e = use_pat ? (8'(i) ^ 8'hA5) : col;
            if (ram[i] !== e) bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        int bc, dn, dn_at, errs, guard;
        logic [2:0] pipe;

        for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);
        rdata = '0;
        idle_in();

        //      dr da  wv wa   wd     rdy men mwe ma   mwd    dv dd
        tbl[0]  = mk(0, 0,  0, 0,   8'h00, 1, 0, 0, 0,   8'h00, 0, 8'h00);
        tbl[1]  = mk(1, 0,  0, 0,   8'h00, 0, 0, 0, 0,   8'h00, 0, 8'h00);
        tbl[2]  = mk(1, 1,  0, 0,   8'h00, 0, 1, 0, 0,   8'h00, 0, 8'h00);
        tbl[3]  = mk(1, 2,  0, 0,   8'h00, 0, 1, 0, 1,   8'h00, 0, 8'h00);
        tbl[4]  = mk(1, 3,  0, 0,   8'h00, 0, 1, 0, 2,   8'h00, 1, 8'h00);
        tbl[5]  = mk(0, 0,  0, 0,   8'h00, 1, 1, 0, 3,   8'h00, 1, 8'h01);
        tbl[6]  = mk(0, 0,  0, 0,   8'h00, 1, 0, 0, 0,   8'h00, 1, 8'h02);
        tbl[7]  = mk(1, 10, 1, 100, 8'hE0, 0, 0, 0, 0,   8'h00, 1, 8'h03);
        tbl[8]  = mk(1, 11, 1, 100, 8'hE0, 0, 1, 0, 10,  8'h00, 0, 8'h00);
        tbl[9]  = mk(1, 12, 1, 100, 8'hE0, 0, 1, 0, 11,  8'h00, 0, 8'h00);
        tbl[10] = mk(1, 13, 1, 100, 8'hE0, 0, 1, 0, 12,  8'h00, 1, 8'h0A);
        tbl[11] = mk(1, 14, 1, 100, 8'hE0, 0, 1, 0, 13,  8'h00, 1, 8'h0B);
        tbl[12] = mk(0, 0,  1, 100, 8'hE0, 1, 1, 0, 14,  8'h00, 1, 8'h0C);
        tbl[13] = mk(0, 0,  0, 0,   8'h00, 1, 1, 1, 100, 8'hE0, 1, 8'h0D);
        tbl[14] = mk(1, 100,0, 0,   8'h00, 0, 0, 0, 0,   8'h00, 1, 8'h0E);
        tbl[15] = mk(0, 0,  0, 0,   8'h00, 1, 1, 0, 100, 8'h00, 0, 8'h00);
        tbl[16] = mk(0, 0,  0, 0,   8'h00, 1, 0, 0, 0,   8'h00, 0, 8'h00);
        tbl[17] = mk(0, 0,  0, 0,   8'h00, 1, 0, 0, 0,   8'h00, 1, 8'hE0);

        repeat (3) @(negedge clk);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_busy", 32'(bus.clr_busy), 32'd0);
        chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        rst_n = 1'b1;

        // Display pipeline and writer contention vectors.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_mem", i),
                {bus.mem_en, bus.mem_we, 7'd0, bus.mem_addr, bus.mem_wdata},
                {tbl[i].men, tbl[i].mwe, 7'd0, tbl[i].ma, tbl[i].mwd});
            chk($sformatf("v%0d_dv", i), 32'(bus.disp_valid), 32'(tbl[i].dv));
            if (tbl[i].dv)
                chk($sformatf("v%0d_dd", i), 32'(bus.disp_data), 32'(tbl[i].dd));
            bus.disp_req  = tbl[i].dr;
            bus.disp_addr = tbl[i].da;
            bus.wr_valid  = tbl[i].wv;
            bus.wr_addr   = tbl[i].wa;
            bus.wr_data   = tbl[i].wd;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(bus.wr_ready), 32'(tbl[i].rdy));
        end
        @(negedge clk);
        idle_in();

        // Clear with simultaneous writer, plus an ignored second start.
        @(negedge clk);
        bus.clr_start = 1'b1;
        bus.clr_color = 8'h1C;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = AW'(100);
        bus.wr_data   = 8'hE7;
        #1;
        chk("clr_wr_rdy", 32'(bus.wr_ready), 32'd1);
        @(negedge clk);
        bus.clr_start = 1'b0;
        chk("clr_wr_issue", {bus.mem_en, bus.mem_we, 7'd0, bus.mem_addr,
            bus.mem_wdata}, {1'b1, 1'b1, 7'd0, AW'(100), 8'hE7});
        chk("clr_busy_on", 32'(bus.clr_busy), 32'd1);
        #1;
        chk("clr_wr_stall", 32'(bus.wr_ready), 32'd0);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        chk("clr_first_wr", {bus.mem_en, bus.mem_we, 7'd0, bus.mem_addr,
            bus.mem_wdata}, {1'b1, 1'b1, 7'd0, AW'(0), 8'h1C});
        bc = 2; dn = 0; dn_at = 0; guard = 0;
        while (guard < 20000) begin
            @(negedge clk);
            guard++;
            bus.clr_start = (guard == 100);
            bus.clr_color = (guard == 100) ? 8'h03 : 8'h00;
            if (!bus.clr_busy) break;
            bc++;
            if (bus.clr_done) begin dn++; dn_at = bc; end
        end
        bus.clr_start = 1'b0;
        chk("clr_busy_cycles", 32'(bc), 32'd19201);
        chk("clr_done_pulses", 32'(dn), 32'd1);
        chk("clr_done_last", 32'(dn_at), 32'd19201);
        repeat (2) @(negedge clk);
        ram_check("clr_ram", 0, DEPTH - 1, 8'h1C, 1'b0);

        // Clear interleaved with display fetches every other cycle.
        @(negedge clk);
        bus.clr_start = 1'b1;
        bus.clr_color = 8'h55;
        pipe = 3'b000; bc = 0; dn = 0; errs = 0; guard = 0;
        while (guard < 40000) begin
            @(negedge clk);
            bus.clr_start = 1'b0;
            if (bus.disp_valid !== pipe[2]) errs++;
            if (bus.disp_valid && guard >= 12 && bus.disp_data !== 8'h55)
                errs++;
            if (!bus.clr_busy) break;
            bc++;
            if (bus.clr_done) dn++;
            bus.disp_req  = (guard % 2 == 0);
            bus.disp_addr = '0;
            pipe = {pipe[1:0], bus.disp_req};
            guard++;
        end
        for (int k = 0; k < 4; k++) begin
            bus.disp_req = 1'b0;
            pipe = {pipe[1:0], 1'b0};
            @(negedge clk);
            if (bus.disp_valid !== pipe[2]) errs++;
        end
        chk("mix_busy_cycles", 32'(bc), 32'd38401);
        chk("mix_done_pulses", 32'(dn), 32'd1);
        chk("mix_latency_errs", 32'(errs), 32'd0);
        ram_check("mix_ram", 0, DEPTH - 1, 8'h55, 1'b0);

        // Reset in the middle of a clear at clr_addr 500.
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i) ^ 8'hA5;
        @(negedge clk);
        bus.clr_start = 1'b1;
        bus.clr_color = 8'h77;
        dn = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            bus.clr_start = 1'b0;
            if (bus.clr_done) dn++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_mem", {bus.mem_en, bus.mem_we, 7'd0, bus.mem_addr,
            bus.mem_wdata}, 32'd0);
        chk("mid_rst_busy", 32'({bus.clr_busy, bus.clr_done}), 32'd0);
        chk("mid_rst_disp", 32'({bus.disp_valid, bus.disp_data}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        if (bus.clr_done) dn++;
        chk("mid_rst_idle", 32'(bus.clr_busy), 32'd0);
        chk("mid_rst_no_done", 32'(dn), 32'd0);
        ram_check("mid_rst_low", 0, 499, 8'h77, 1'b0);
        ram_check("mid_rst_high", 500, DEPTH - 1, 8'h00, 1'b1);

        // A fresh clear is accepted after reset release.
        bus.clr_start = 1'b1;
        bus.clr_color = 8'h33;
        dn = 0; guard = 0;
        while (guard < 20000 && dn == 0) begin
            @(negedge clk);
            bus.clr_start = 1'b0;
            guard++;
            if (bus.clr_done) dn++;
        end
        chk("reclr_done", 32'(dn), 32'd1);
        repeat (2) @(negedge clk);
        ram_check("reclr_ram", 0, DEPTH - 1, 8'h33, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, framebuffer address width.
REQ-002 Parameter FB_DEPTH, default 19200, number of framebuffer pixels (160x120).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 disp_req  input  1  scan-out pixel fetch request, one per cycle max.
REQ-006 disp_addr  input  ADDR_W  scan-out fetch address.
REQ-007 disp_data  output  8  fetched pixel {R[2:0],G[2:0],B[1:0]}.
REQ-008 disp_valid  output  1  disp_data valid this cycle.
REQ-009 wr_valid  input  1  writer (snow/switch painter) offers a pixel write.
REQ-010 wr_ready  output  1  writer transfer accepted when wr_valid && wr_ready.
REQ-011 wr_addr  input  ADDR_W  writer address.
REQ-012 wr_data  input  8  writer pixel.
REQ-013 clr_start  input  1  start full-screen clear.
REQ-014 clr_color  input  8  clear colour, sampled with clr_start.
REQ-015 clr_busy  output  1  clear in progress.
REQ-016 clr_done  output  1  one-cycle pulse at clear completion.
REQ-017 mem_en, mem_we  output  1 each  single-port RAM enable / write enable.
REQ-018 mem_addr  output  ADDR_W; mem_wdata  output  8  RAM address / write data.
REQ-019 mem_rdata  input  8  RAM read data, valid the cycle after a read with mem_en=1, mem_we=0.

Function
REQ-020 Fixed priority per cycle: display > clear > writer; exactly one RAM access per cycle max.
REQ-021 disp_req at cycle t SHALL drive mem_en=1, mem_we=0, mem_addr=disp_addr (registered) at t+1; disp_data=mem_rdata and disp_valid=1 registered at t+3; latency fixed at 3, back-to-back requests give back-to-back valids.
REQ-022 wr_ready SHALL be combinational: 1 iff state=IDLE and disp_req=0 and rst_n=1.
REQ-023 An accepted writer transfer at cycle t SHALL drive mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data at t+1.
REQ-024 FSM states IDLE, CLEAR, DONE. IDLE->CLEAR on clr_start (latch clr_color, clr_addr:=0); CLEAR->DONE after write of address FB_DEPTH-1 issued; DONE->IDLE after one cycle.
REQ-025 In CLEAR, each cycle with disp_req=0 SHALL issue a write of latched colour to clr_addr at next cycle and increment clr_addr; cycles with disp_req=1 SHALL stall clr_addr.
REQ-026 clr_busy=1 in CLEAR and DONE; clr_done=1 only in DONE; writer stalled (wr_ready=0) throughout.
REQ-027 clr_start while CLEAR or DONE SHALL be ignored; clr_start and wr_valid simultaneously in IDLE: writer transfer accepted this cycle, clear starts next cycle.
REQ-028 clr_addr SHALL never exceed FB_DEPTH-1; no wrap.
REQ-029 Cycles with no grant SHALL drive mem_en=0, mem_we=0.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force state=IDLE, clr_addr=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_valid=0, disp_data=0, clr_busy=0, clr_done=0; in-flight reads and clears discarded.
REQ-031 Reset asserted mid-clear SHALL abandon the clear without a clr_done pulse.

Verification
REQ-032 Display only: disp_req=1 with addr 0..3 over 4 cycles, RAM model preloaded addr=data -> disp_valid cycles t+3..t+6 with disp_data 0,1,2,3.
REQ-033 Contention: wr_valid=1 addr 100 data 8'hE0 with disp_req=1 for 5 cycles -> wr_ready=0 for those 5 cycles, write to 100 issued cycle after disp_req drops.
REQ-034 Clear: clr_start with clr_color 8'h1C, no traffic -> clr_busy for 19201 cycles, clr_done single pulse, all 19200 RAM words = 8'h1C.
REQ-035 Clear with interleaved display every other cycle -> clear completes in ~38400 cycles, every disp_req still returns at latency 3.
REQ-036 Reset at clr_addr=500 -> outputs at reset values next cycle, no clr_done, words 500+ unchanged; second clr_start accepted after release.
REQ-037 clr_start during CLEAR with different colour -> ignored; final RAM contents use first colour.
